// File: rtl/eq_cmp_arbiter_pkg.sv
// Shared definitions for the round-robin equality-compare arbiter.
package eq_cmp_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam int EQ_COUNT_MAX  = 255;
    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 4;

endpackage

// File: rtl/eq_cmp_arbiter_cmp.sv
// Shared equality comparator; the only compare logic in the arbiter.
module equality_comparator_4bit #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         equal
);

    assign equal = (A == B);

endmodule

// File: rtl/eq_cmp_arbiter.sv
// N_REQ requesters share one equality comparator through a round-robin grant;
// one registered result is offered per cycle on a valid/ready response port.
module eq_cmp_arbiter
    import eq_cmp_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int W     = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_equal,
    output logic [7:0]               eq_count,
    output state_e                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and payload are held by the source until that edge.

    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [7:0]     eq_count_q, eq_count_d;

    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           accept;
    logic           cmp_equal;
    logic           deliver;
    int             j;

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_a     = '0;
        sel_b     = '0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!sel_found && req_valid[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(j);
                sel_a     = req_a[j*W +: W];
                sel_b     = req_b[j*W +: W];
            end
        end
    end

    assign accept = sel_found && ((state_q == IDLE) || rsp_ready);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && (sel_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    equality_comparator_4bit #(
        .W (W)
    ) u_cmp (
        .A     (a_q),
        .B     (b_q),
        .equal (cmp_equal)
    );

    // Operand registers reset to zero, which compare equal; gate with valid.
    assign rsp_valid = (state_q == RESP);
    assign rsp_equal = rsp_valid && cmp_equal;
    assign rsp_id    = id_q;
    assign eq_count  = eq_count_q;
    assign dbg_state = state_q;
    assign deliver   = rsp_valid && rsp_ready && rsp_equal;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        eq_count_d = eq_count_q;
        if (accept) begin
            state_d = RESP;
            id_d    = sel_idx;
            a_d     = sel_a;
            b_d     = sel_b;
            ptr_d   = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
        end else if ((state_q == RESP) && rsp_ready) begin
            state_d = IDLE;
        end
        if (deliver && (eq_count_q != 8'(EQ_COUNT_MAX))) begin
            eq_count_d = eq_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            eq_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            eq_count_q <= eq_count_d;
        end
    end

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Directed bench for eq_cmp_arbiter with N_REQ=4, W=4.
module tb_eq_cmp_arbiter;
    import eq_cmp_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic        rsp_equal;
    logic [7:0]  eq_count;
    state_e      dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    eq_cmp_arbiter #(.N_REQ(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_equal (rsp_equal),
        .eq_count  (eq_count),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    // Ends one cycle after release, at posedge+1 with the block idle.
    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_equal !== 1'b0) begin n_fail++; $display("FAIL reset_equal: got %b want 0", rsp_equal); end
        n_cmp++; if (eq_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", eq_count); end
        n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready); end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_ready_comb: got %b want 0001", req_ready); end
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        req_valid = 4'b0001; set_op(0, 4'b1010, 4'b1010); rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_equal !== 1'b1) begin n_fail++; $display("FAIL single_equal: got %b want 1", rsp_equal); end
        n_cmp++; if (eq_count !== 8'd0) begin n_fail++; $display("FAIL single_count_pre: got %0d want 0", eq_count); end
        @(posedge clk); #1;
        n_cmp++; if (eq_count !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", eq_count); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [5];
        logic [1:0] id;
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        // Even requesters compare equal, odd ones differ in bit 3.
        set_op(0, 4'd0, 4'd0); set_op(1, 4'd1, 4'd9);
        set_op(2, 4'd2, 4'd2); set_op(3, 4'd3, 4'd11);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_cmp++; if (req_ready !== (4'b0001 << seq[g])) begin n_fail++; $display("FAIL rr_grant%0d: got %b want id %0d", g, req_ready, seq[g]); end
            if (g > 0) begin
                id = exp_q.pop_front();
                n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid%0d: got %b want 1", g, rsp_valid); end
                n_cmp++; if (rsp_id !== id) begin n_fail++; $display("FAIL rr_id%0d: got %0d want %0d", g, rsp_id, id); end
                n_cmp++; if (rsp_equal !== ~id[0]) begin n_fail++; $display("FAIL rr_equal%0d: got %b want %b", g, rsp_equal, ~id[0]); end
            end
            exp_q.push_back(seq[g]);
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        #1;
        id = exp_q.pop_front();
        n_cmp++; if (rsp_id !== id) begin n_fail++; $display("FAIL rr_last_id: got %0d want %0d", rsp_id, id); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_no_ready: got %b want 0000", req_ready); end
        n_cmp++; if (eq_count !== 8'd2) begin n_fail++; $display("FAIL rr_count_pre: got %0d want 2", eq_count); end
        @(posedge clk); #1;
        n_cmp++; if (eq_count !== 8'd3) begin n_fail++; $display("FAIL rr_count: got %0d want 3", eq_count); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        // Entry: idle, ptr=1, eq_count=3, rsp_ready=1.
        req_valid = 4'b0100; set_op(2, 4'b0000, 4'b0001); rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0001; set_op(0, 4'b0101, 4'b0101);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", c, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id%0d: got %0d want 2", c, rsp_id); end
            n_cmp++; if (rsp_equal !== 1'b0) begin n_fail++; $display("FAIL bp_equal%0d: got %b want 0", c, rsp_equal); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
            n_cmp++; if (eq_count !== 8'd3) begin n_fail++; $display("FAIL bp_count%0d: got %0d want 3", c, eq_count); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_next_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_equal !== 1'b1) begin n_fail++; $display("FAIL bp_next_equal: got %b want 1", rsp_equal); end
        n_cmp++; if (eq_count !== 8'd3) begin n_fail++; $display("FAIL bp_count_held: got %0d want 3", eq_count); end
        @(posedge clk); #1;
        n_cmp++; if (eq_count !== 8'd4) begin n_fail++; $display("FAIL bp_count_after: got %0d want 4", eq_count); end
    endtask

    task automatic test_saturation();
        apply_reset();
        req_valid = 4'b0001; set_op(0, 4'b1111, 4'b1111); rsp_ready = 1'b1;
        // After edge k, k-1 equal results have been delivered.
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk); #1;
            if (k == 255) begin
                n_cmp++; if (eq_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", eq_count); end
            end
            if (k == 256) begin
                n_cmp++; if (eq_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", eq_count); end
            end
        end
        req_valid = '0;
        @(posedge clk); #1;
        n_cmp++; if (eq_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", eq_count); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sat_idle: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_resp();
        req_valid = 4'b0100; set_op(2, 4'b0011, 4'b0011); rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", rsp_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (eq_count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", eq_count); end
        n_cmp++; if (rsp_equal !== 1'b0) begin n_fail++; $display("FAIL mid_equal: got %b want 0", rsp_equal); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_id: got %0d want 0", rsp_id); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        req_valid = 4'b1010; set_op(1, 4'd6, 4'd6); set_op(3, 4'd7, 4'd7); rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL mid_first_id: got %0d want 1", rsp_id); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_second_grant: got %b want 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int n0;
        int n1;
        logic [3:0] exp_ready;
        logic [1:0] id;
        n0 = 0;
        n1 = 0;
        apply_reset();
        req_valid = 4'b0011; set_op(0, 4'd4, 4'd4); set_op(1, 4'd5, 4'd5); rsp_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            exp_ready = (g % 2 == 0) ? 4'b0001 : 4'b0010;
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, exp_ready); end
            if (req_ready[0]) n0++;
            if (req_ready[1]) n1++;
            if (g > 0) begin
                id = exp_q.pop_front();
                n_cmp++; if (rsp_id !== id) begin n_fail++; $display("FAIL fair_id%0d: got %0d want %0d", g, rsp_id, id); end
            end
            exp_q.push_back((g % 2 == 0) ? 2'd0 : 2'd1);
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        #1;
        id = exp_q.pop_front();
        n_cmp++; if (rsp_id !== id) begin n_fail++; $display("FAIL fair_last_id: got %0d want %0d", rsp_id, id); end
        n_cmp++; if (n0 !== 5) begin n_fail++; $display("FAIL fair_n0: got %0d want 5", n0); end
        n_cmp++; if (n1 !== 5) begin n_fail++; $display("FAIL fair_n1: got %0d want 5", n1); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid_resp();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
